// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller: load-use stalls, branch/jump redirects and
// data-memory wait states, with a saturating stall counter and sticky timeout flag.
module hazard_ctrl #(
  parameter int XLEN        = 64,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

  state_t      cur, nxt;
  logic        freeze, take_redir, load_use, capture;
  logic [15:0] wait_cnt, wait_nxt;

  assign freeze     = mem_req & ~mem_ack;
  assign take_redir = ex_valid & ex_redirect;
  assign load_use   = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd)));
  assign state      = cur;

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    flush_id  = 1'b0;
    bubble_ex = 1'b0;
    capture   = 1'b0;
    nxt       = cur;
    wait_nxt  = wait_cnt;
    if (freeze) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      stall_ex = 1'b1;
      nxt      = (cur == REDIRECT) ? REDIRECT : MEM_WAIT;
      wait_nxt = (wait_cnt >= TIMEOUT) ? TIMEOUT : wait_cnt + 16'd1;
    end else begin
      wait_nxt = 16'd0;
      // A leaving MEM_WAIT cycle follows the RUN rules, so only REDIRECT differs.
      if (take_redir) begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
        capture   = 1'b1;
        nxt       = REDIRECT;
      end else begin
        nxt = RUN;
        if (cur == REDIRECT) begin
          flush_id = 1'b1;
        end else if (load_use) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
        end
      end
    end
    // Keep decode and execute empty while the core is held in reset.
    if (!resetn) begin
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      stall_ex  = 1'b0;
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur            <= RUN;
      wait_cnt       <= 16'd0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      mem_timeout    <= 1'b0;
      stall_cycles   <= '0;
    end else begin
      cur            <= nxt;
      wait_cnt       <= wait_nxt;
      redirect_valid <= (nxt == REDIRECT);
      if (capture)
        redirect_pc <= ex_target;
      if (wait_nxt == TIMEOUT)
        mem_timeout <= 1'b1;
      if (stall_id && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the RISC-V core. Sits beside the decode stage and drives its `flush` and `stall` inputs. It also drives the fetch, execute and memory stage controls. It resolves load-use hazards, taken branch/jump redirects and data-memory wait states, and keeps a stall-cycle performance counter plus a sticky memory-timeout flag.

## Interface
- `XLEN`, 64, architectural register/PC width
- `MEM_TIMEOUT`, 255, consecutive freeze cycles before `mem_timeout` sets (1..65535)
- `CNT_W`, 32, width of `stall_cycles`
- `clk` in 1: clock
- `resetn` in 1: reset, asynchronous, active-low
- `id_valid` in 1: decode stage holds a real instruction
- `id_rs1`, `id_rs2` in 5 each: source register indices of the instruction in decode
- `id_uses_rs1`, `id_uses_rs2` in 1 each: instruction reads rs1 / rs2
- `ex_valid` in 1: execute stage holds a real instruction
- `ex_rd` in 5: execute-stage destination register
- `ex_mem_read` in 1: execute-stage instruction is a load
- `ex_redirect` in 1: execute resolved a taken branch, JAL or JALR
- `ex_target` in XLEN: redirect target PC
- `mem_req` in 1: memory stage has an outstanding data access
- `mem_ack` in 1: data memory completes the access this cycle
- `stall_if`, `stall_id`, `stall_ex` out 1: hold the respective stage registers
- `flush_id` out 1: squash the instruction being latched into decode (to decode `flush`)
- `bubble_ex` out 1: insert a NOP into execute instead of the decode result
- `redirect_valid` out 1: fetch loads `redirect_pc`
- `redirect_pc` out XLEN: registered redirect target
- `mem_timeout` out 1: sticky error flag
- `stall_cycles` out CNT_W: saturating count of cycles with `stall_id`=1
- `state` out 2: FSM state (0 RUN, 1 REDIRECT, 2 MEM_WAIT)

## Operation
- `freeze` = `mem_req` & !`mem_ack`. While it is 1: `stall_if`=`stall_id`=`stall_ex`=1, `flush_id`=0, `bubble_ex`=0, and no redirect capture. This has the highest priority in every state.
- `load_use` = `ex_valid` & `ex_mem_read` & (`ex_rd`≠0) & `id_valid` & ((`id_uses_rs1` & `id_rs1`==`ex_rd`) | (`id_uses_rs2` & `id_rs2`==`ex_rd`)).
- RUN behaviour, with `freeze`=0, in priority order:
  - `ex_valid` & `ex_redirect`: `flush_id`=1 and `bubble_ex`=1. Latch `ex_target` into `redirect_pc`. Go to REDIRECT. Any `load_use` in the same cycle is ignored, because the decode instruction is on the wrong path.
  - Otherwise `load_use`: `stall_if`=`stall_id`=1 and `bubble_ex`=1 for this cycle only. The load advances, so the hazard clears next cycle.
  - Otherwise all controls are 0.
- REDIRECT: `redirect_valid`=1 and `flush_id`=1, which kills the second wrong-path fetch.
  - With `freeze`=0, return to RUN next cycle.
  - With `freeze`=1, stay in REDIRECT. `redirect_valid` remains 1 and `redirect_pc` is held.
  - A new `ex_valid`&`ex_redirect` seen in REDIRECT with `freeze`=0 overwrites `redirect_pc` and stays in REDIRECT: latest target wins.
- MEM_WAIT: entered from RUN on `freeze`; REDIRECT takes precedence when already in REDIRECT.
  - `wait_cnt` (16 bit) increments per `freeze` cycle, saturating at `MEM_TIMEOUT`.
  - When `wait_cnt` reaches `MEM_TIMEOUT`, `mem_timeout` sets and stays set until reset. The pipeline remains frozen.
  - On `mem_ack`, `wait_cnt` clears and the FSM returns to RUN the same cycle. RUN rules apply that cycle.
- `stall_cycles` increments on every clock edge where `stall_id`=1 and holds at all-ones.
- While `resetn`=0: `flush_id`=1 and `bubble_ex`=1, stalls are 0.

## Timing
- Reset values: `state`=RUN, `redirect_valid`=0, `redirect_pc`=0, `mem_timeout`=0, `stall_cycles`=0, `wait_cnt`=0.
- Reset asserted mid-operation clears all of these immediately, with no clock required.
- `stall_*`, `flush_id` and `bubble_ex` are combinational from the inputs and the current state, with zero latency.
- `redirect_valid` and `redirect_pc` are registered: 1-cycle latency from `ex_redirect`.
- Branch penalty is 2 cycles: flush in the resolve cycle plus flush in the REDIRECT cycle.
- Load-use penalty is exactly 1 cycle.
- `mem_ack` without `mem_req` is ignored.
- `mem_req` & `mem_ack` in the same cycle is zero-wait: no stall, and `wait_cnt` is unchanged at 0.

## Test plan
- Load-use stall:
  - Stimulus: `ex_valid`=1, `ex_mem_read`=1, `ex_rd`=5; `id_valid`=1, `id_uses_rs2`=1, `id_rs2`=5.
  - Required: `stall_if`=`stall_id`=`bubble_ex`=1 for 1 cycle and `stall_cycles`=1.
  - Repeat with `ex_rd`=0: no stall.
- Branch redirect:
  - Stimulus: `ex_redirect`=1 with `ex_target`=0x80000040 at cycle N.
  - Required: cycle N has `flush_id`=`bubble_ex`=1. Cycle N+1 has `redirect_valid`=1, `redirect_pc`=0x80000040, `flush_id`=1. Cycle N+2 is RUN with all controls 0.
- Redirect priority:
  - Stimulus: `ex_redirect` and a `load_use` condition in the same cycle.
  - Required: no stall, flush only, and `stall_cycles` unchanged.
- Memory wait:
  - Stimulus: `mem_req`=1 held, `mem_ack` asserted on the 4th cycle.
  - Required: all stalls = 1 for 3 cycles, `state`=MEM_WAIT, then RUN; `stall_cycles`=3.
- Timeout:
  - Stimulus: `MEM_TIMEOUT`=4, `mem_req`=1 with no ack for 10 cycles.
  - Required: `mem_timeout` rises after the 4th freeze cycle and stays 1 after the ack.
  - Reset clears it.
- Freeze during REDIRECT and reset:
  - Stimulus: enter REDIRECT, then `freeze` for 2 cycles.
  - Required: `redirect_valid` holds 1 with a stable `redirect_pc`, then returns to RUN.
  - Asserting `resetn`=0 mid-REDIRECT immediately gives `redirect_valid`=0 and `state`=RUN.
